// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS main control FSM with registered outputs.
// Optional MULTICYCLE_MEM_WAIT_EN adds MemReady stalls in FETCH, MEMRD and MEMWR.
module multicycle_control #(
  parameter int STATE_W      = 4,
  parameter int ILLEGAL_HALT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         Opcode,
  input  logic               Zero,
`ifdef MULTICYCLE_MEM_WAIT_EN
  input  logic               MemReady,
`endif
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic               Inm,
  output logic [3:0]         ALUOpFinal,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 4'd0,  FETCH    = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
    MEMRD    = 4'd4,  MEMWB    = 4'd5,  MEMWR  = 4'd6,  RTYPE_EX = 4'd7,
    RTYPE_WB = 4'd8,  BEQ_EX   = 4'd9,  IMM_EX = 4'd10, IMM_WB = 4'd11,
    JUMP     = 4'd12, HALT     = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       inm;
    logic [3:0] alu_op_final;
    logic       illegal;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       illegal_d;
  logic       mem_ready;
  logic       unused_zero;

  assign unused_zero = Zero;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH:    state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        op_d = Opcode;
        case (Opcode)
          OP_R:                            state_d = RTYPE_EX;
          OP_LW, OP_SW:                    state_d = MEMADR;
          OP_BEQ:                          state_d = BEQ_EX;
          OP_J:                            state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = IMM_EX;
          default: begin
            state_d   = (ILLEGAL_HALT != 0) ? HALT : FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR:   state_d = (op_q == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:    state_d = mem_ready ? FETCH : MEMWR;
      RTYPE_EX: state_d = RTYPE_WB;
      IMM_EX:   state_d = IMM_WB;
      HALT:     state_d = HALT;
      default:  state_d = FETCH;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet match the current state.
  always_comb begin
    ctrl_d         = '0;
    ctrl_d.illegal = illegal_d;
    case (state_d)
      FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.ir_write  = 1'b1;
        ctrl_d.alu_src_b = 2'b01;
        ctrl_d.pc_write  = 1'b1;
      end
      DECODE:   ctrl_d.alu_src_b = 2'b11;
      MEMADR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
      end
      MEMRD: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.iord     = 1'b1;
      end
      MEMWB: begin
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
      end
      MEMWR: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.iord      = 1'b1;
      end
      RTYPE_EX: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_op    = 2'b10;
      end
      RTYPE_WB: begin
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      BEQ_EX: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_op        = 2'b01;
        ctrl_d.pc_write_cond = 1'b1;
        ctrl_d.pc_source     = 2'b01;
      end
      IMM_EX: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
        ctrl_d.inm       = 1'b1;
        case (op_d)
          OP_ADDI: ctrl_d.alu_op_final = 4'b0010;
          OP_ANDI: ctrl_d.alu_op_final = 4'b0000;
          OP_ORI:  ctrl_d.alu_op_final = 4'b0001;
          OP_SLTI: ctrl_d.alu_op_final = 4'b0111;
          default: ctrl_d.alu_op_final = 4'b0000;
        endcase
      end
      IMM_WB:   ctrl_d.reg_write = 1'b1;
      JUMP: begin
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.pc_source = 2'b10;
      end
      default:  ctrl_d = ctrl_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // ir_write marks FETCH, so only the fetch-time PC load waits for memory.
  assign PCWrite     = ctrl_q.pc_write & (mem_ready | ~ctrl_q.ir_write);
  assign IRWrite     = ctrl_q.ir_write & mem_ready;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign IorD        = ctrl_q.iord;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign MemtoReg    = ctrl_q.mem_to_reg;
  assign RegDst      = ctrl_q.reg_dst;
  assign RegWrite    = ctrl_q.reg_write;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign PCSource    = ctrl_q.pc_source;
  assign ALUOp       = ctrl_q.alu_op;
  assign Inm         = ctrl_q.inm;
  assign ALUOpFinal  = ctrl_q.alu_op_final;
  assign Illegal     = ctrl_q.illegal;
  assign State       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized bench for multicycle_control against a path-table model.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n, rst_n_h;
  logic [5:0]  op_in, op_h;
  logic        mem_ready = 1'b1;
  logic [25:0] outs, h_outs;
  logic [3:0]  State, State_h;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Opcode(op_in), .Zero(1'b0),
`ifdef MULTICYCLE_MEM_WAIT_EN
    .MemReady(mem_ready),
`endif
    .PCWrite(outs[25]), .PCWriteCond(outs[24]), .IorD(outs[23]), .MemRead(outs[22]),
    .MemWrite(outs[21]), .IRWrite(outs[20]), .MemtoReg(outs[19]), .RegDst(outs[18]),
    .RegWrite(outs[17]), .ALUSrcA(outs[16]), .ALUSrcB(outs[15:14]), .PCSource(outs[13:12]),
    .ALUOp(outs[11:10]), .Inm(outs[9]), .ALUOpFinal(outs[8:5]), .Illegal(outs[4]),
    .State(State)
  );
  assign outs[3:0] = State;

  multicycle_control #(.ILLEGAL_HALT(1)) dut_h (
    .clk(clk), .rst_n(rst_n_h), .Opcode(op_h), .Zero(1'b0),
`ifdef MULTICYCLE_MEM_WAIT_EN
    .MemReady(1'b1),
`endif
    .PCWrite(h_outs[25]), .PCWriteCond(h_outs[24]), .IorD(h_outs[23]), .MemRead(h_outs[22]),
    .MemWrite(h_outs[21]), .IRWrite(h_outs[20]), .MemtoReg(h_outs[19]), .RegDst(h_outs[18]),
    .RegWrite(h_outs[17]), .ALUSrcA(h_outs[16]), .ALUSrcB(h_outs[15:14]), .PCSource(h_outs[13:12]),
    .ALUOp(h_outs[11:10]), .Inm(h_outs[9]), .ALUOpFinal(h_outs[8:5]), .Illegal(h_outs[4]),
    .State(State_h)
  );
  assign h_outs[3:0] = State_h;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit supported(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                      6'b001000, 6'b001100, 6'b001101, 6'b001010};
  endfunction

  function automatic int latency(input logic [5:0] op);
    case (op)
      6'b100011:                                  return 5;
      6'b101011, 6'b000000:                       return 4;
      6'b001000, 6'b001100, 6'b001101, 6'b001010: return 4;
      6'b000100, 6'b000010:                       return 3;
      default:                                    return 2;
    endcase
  endfunction

  int route[$];

  // States visited after FETCH for one instruction.
  function automatic void fill_route(input logic [5:0] op);
    route.delete();
    route.push_back(2);
    case (op)
      6'b100011: begin route.push_back(3); route.push_back(4); route.push_back(5); end
      6'b101011: begin route.push_back(3); route.push_back(6); end
      6'b000000: begin route.push_back(7); route.push_back(8); end
      6'b000100: route.push_back(9);
      6'b000010: route.push_back(12);
      6'b001000, 6'b001100, 6'b001101, 6'b001010: begin route.push_back(10); route.push_back(11); end
      default: ;
    endcase
  endfunction

  function automatic logic [25:0] exp_outs(input int st, input logic [5:0] op, input bit ill, input bit rdy);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, inm;
    logic [1:0] srcb, pcs, aop;
    logic [3:0] aof;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, inm} = '0;
    {srcb, pcs, aop, aof} = '0;
    case (st)
      1:  begin mrd = 1; irw = rdy; pcw = rdy; srcb = 2'b01; end
      2:  srcb = 2'b11;
      3:  begin srca = 1; srcb = 2'b10; end
      4:  begin mrd = 1; iord = 1; end
      5:  begin m2r = 1; rw = 1; end
      6:  begin mwr = 1; iord = 1; end
      7:  begin srca = 1; aop = 2'b10; end
      8:  begin rdst = 1; rw = 1; end
      9:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      10: begin
        srca = 1; srcb = 2'b10; inm = 1;
        aof = (op == 6'b001000) ? 4'd2 : (op == 6'b001101) ? 4'd1 : (op == 6'b001010) ? 4'd7 : 4'd0;
      end
      11: rw = 1;
      12: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, pcs, aop, inm, aof, ill, 4'(st)};
  endfunction

  logic [5:0] dir_ops [10] = '{6'b100011, 6'b000000, 6'b000100, 6'b001101, 6'b111111,
                               6'b101011, 6'b000010, 6'b001000, 6'b001100, 6'b001010};
  logic [5:0] sup_ops [9]  = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                               6'b001000, 6'b001100, 6'b001101, 6'b001010};

  initial begin
    int         exp_state, lat, dir_i;
    bit         exp_ill, stall, stalled, have_instr;
    logic [5:0] cur_op;
    logic [3:0] prev_st;

    rst_n = 1'b0; rst_n_h = 1'b0; op_in = '0; op_h = 6'b111111;
    exp_state = 0; exp_ill = 0; stalled = 0; have_instr = 0; lat = 0; dir_i = 0;
    cur_op = '0; prev_st = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_outs", 32'(outs), 32'd0);
    check_eq("reset_outs_h", 32'(h_outs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc > 40 && $urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        #1;
        check_eq("reset_mid_instr", 32'(outs), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_state = 0; exp_ill = 0; have_instr = 0; prev_st = '0;
        route.delete();
      end
      op_in = (exp_state == 2) ? cur_op : 6'($urandom);
`ifdef MULTICYCLE_MEM_WAIT_EN
      mem_ready = ($urandom_range(0, 3) != 0);
`endif
      #1;
      check_eq($sformatf("state%0d_outs", exp_state), 32'(outs),
               32'(exp_outs(exp_state, cur_op, exp_ill, mem_ready)));

      if (State == 4'd1 && prev_st != 4'd1) begin
        if (have_instr && !stalled && prev_st != 4'd0)
          check_eq("fetch_to_fetch", lat, latency(cur_op));
        lat = 0;
        stalled = 0;
      end
      lat++;
      prev_st = State;

      stall = (exp_state == 1 || exp_state == 4 || exp_state == 6) && !mem_ready;
      if (stall) stalled = 1;
      exp_ill = 0;
      if (exp_state == 0) begin
        exp_state = 1;
      end else if (stall) begin
        exp_state = exp_state;
      end else if (exp_state == 1) begin
        if (dir_i < 10) begin
          cur_op = dir_ops[dir_i];
          dir_i++;
        end else if ($urandom_range(0, 9) < 7) begin
          cur_op = sup_ops[$urandom_range(0, 8)];
        end else begin
          cur_op = 6'($urandom);
        end
        fill_route(cur_op);
        exp_state = route.pop_front();
        have_instr = 1;
      end else begin
        if (exp_state == 2 && !supported(cur_op)) exp_ill = 1;
        exp_state = (route.size() > 0) ? route.pop_front() : 1;
      end
    end

    // Illegal opcode with ILLEGAL_HALT=1 parks in HALT until reset.
    @(negedge clk);
    rst_n_h = 1'b1;
    #1;
    check_eq("halt_idle", 32'(State_h), 32'd0);
    @(negedge clk); #1;
    check_eq("halt_fetch", 32'(State_h), 32'd1);
    @(negedge clk); #1;
    check_eq("halt_decode", 32'(State_h), 32'd2);
    @(negedge clk); #1;
    check_eq("halt_entry_outs", 32'(h_outs), 32'h0000_001D);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check_eq("halt_held_outs", 32'(h_outs), 32'd13);
    end
    rst_n_h = 1'b0;
    #1;
    check_eq("halt_reset", 32'(h_outs), 32'd0);
    @(negedge clk);
    rst_n_h = 1'b1;
    #1;
    check_eq("halt_reset_idle", 32'(State_h), 32'd0);
    @(negedge clk); #1;
    check_eq("halt_refetch", 32'(State_h), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
